// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: one instruction at a time through
// fetch/decode/execute/memory/writeback. Optional macro MCTRL_ILLEGAL_TRAP_EN traps undecoded opcodes.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       alu_sub,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_TRAP      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t state_q, state_d;

    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        state_d   = state_q;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        iord      = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        alu_src_a = 2'b00;
        alu_src_b = 2'b00;
        alu_op    = 2'b00;
        alu_sub   = 1'b0;
        illegal   = 1'b0;
        state     = state_q;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively compute the branch/jump target into ALUOut.
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
`ifdef MCTRL_ILLEGAL_TRAP_EN
                    default:           state_d = S_TRAP;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write = 1'b1;
                wb_sel    = 2'b01;
                state_d   = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b10;
                alu_sub   = funct7[5];
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b01;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                pc_write  = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
                state_d   = S_FETCH;
            end
            S_JAL: begin
                reg_write = 1'b1;
                wb_sel    = 2'b10;
                pc_write  = 1'b1;
                pc_src    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
                illegal = 1'b1;
                state_d = S_TRAP;
`else
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase

        // Reset silences every request immediately, even mid-transaction.
        if (reset) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            iord      = 1'b0;
            reg_write = 1'b0;
            wb_sel    = 2'b00;
            alu_src_a = 2'b00;
            alu_src_b = 2'b00;
            alu_op    = 2'b00;
            alu_sub   = 1'b0;
            illegal   = 1'b0;
            state     = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instruction sequences push hand-derived
// expected output vectors; a negedge monitor pops and compares one per cycle.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       ir_write, pc_write, pc_src, mem_read, mem_write, iord, reg_write, alu_sub, illegal;
    logic [1:0] wb_sel, alu_src_a, alu_src_b, alu_op;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0] st;
        logic       ir_write, pc_write, pc_src, mem_read, mem_write, iord, reg_write;
        logic [1:0] wb_sel, src_a, src_b, alu_op;
        logic       alu_sub, illegal;
    } outs_t;

    outs_t exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .alu_sub(alu_sub), .illegal(illegal), .state(state)
    );

    // Hand-written per-state table; Mealy bits and alu_sub supplied by the caller.
    function automatic outs_t ex(input logic [3:0] s, input logic irw, input logic pcw, input logic sub);
        outs_t e;
        e = '0;
        e.st = s;
        e.ir_write = irw;
        e.pc_write = pcw;
        case (s)
            4'd0:  begin e.mem_read = 1; e.src_b = 2'b01; end
            4'd1:  begin e.src_a = 2'b10; e.src_b = 2'b10; end
            4'd2:  begin e.src_a = 2'b01; e.src_b = 2'b10; end
            4'd3:  begin e.mem_read = 1; e.iord = 1; end
            4'd4:  begin e.reg_write = 1; e.wb_sel = 2'b01; end
            4'd5:  begin e.mem_write = 1; e.iord = 1; end
            4'd6:  begin e.src_a = 2'b01; e.alu_op = 2'b10; e.alu_sub = sub; end
            4'd7:  begin e.src_a = 2'b01; e.src_b = 2'b10; e.alu_op = 2'b11; end
            4'd8:  begin e.reg_write = 1; end
            4'd9:  begin e.src_a = 2'b01; e.alu_op = 2'b01; e.pc_src = 1; end
            4'd10: begin e.reg_write = 1; e.wb_sel = 2'b10; e.pc_write = 1; e.pc_src = 1; end
            4'd11: begin e.illegal = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic cyc(input string nm, input outs_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: the DUT presents a fresh output vector every cycle.
    initial begin
        outs_t act, e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                act = '{state, ir_write, pc_write, pc_src, mem_read, mem_write, iord, reg_write,
                        wb_sel, alu_src_a, alu_src_b, alu_op, alu_sub, illegal};
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL %s: got %h want %h (t=%0t)", nm, act, e, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; mem_ready = 1; zero = 0;
        opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0100000;
        @(posedge clk); #1;

        cyc("reset0", '0);
        cyc("reset1", '0);
        reset = 0;

        // add (sub via funct7[5]); mem_ready ignored in DECODE
        cyc("add_fetch", ex(0, 1, 1, 0));
        mem_ready = 0;
        cyc("add_decode", ex(1, 0, 0, 0));
        mem_ready = 1;
        cyc("add_exec", ex(6, 0, 0, 1));
        cyc("add_wb", ex(8, 0, 0, 0));

        // lw with a 3-cycle stall in MEM_READ
        opcode = 7'b0000011; funct3 = 3'b010;
        cyc("lw_fetch", ex(0, 1, 1, 0));
        cyc("lw_decode", ex(1, 0, 0, 0));
        cyc("lw_addr", ex(2, 0, 0, 0));
        mem_ready = 0;
        for (int i = 0; i < 3; i++) cyc($sformatf("lw_stall%0d", i), ex(3, 0, 0, 0));
        mem_ready = 1;
        cyc("lw_read", ex(3, 0, 0, 0));
        cyc("lw_wb", ex(4, 0, 0, 0));

        // sw, then a stalled fetch
        opcode = 7'b0100011;
        cyc("sw_fetch", ex(0, 1, 1, 0));
        cyc("sw_decode", ex(1, 0, 0, 0));
        cyc("sw_addr", ex(2, 0, 0, 0));
        cyc("sw_write", ex(5, 0, 0, 0));
        mem_ready = 0;
        cyc("fetch_stall0", ex(0, 0, 0, 0));
        cyc("fetch_stall1", ex(0, 0, 0, 0));
        mem_ready = 1;

        // branches: beq taken, beq not taken, bne taken, bne not taken, blt never taken
        opcode = 7'b1100011; funct3 = 3'b000; zero = 1;
        cyc("beq1_fetch", ex(0, 1, 1, 0));
        cyc("beq1_decode", ex(1, 0, 0, 0));
        cyc("beq_taken", ex(9, 0, 1, 0));
        zero = 0;
        cyc("beq2_fetch", ex(0, 1, 1, 0));
        cyc("beq2_decode", ex(1, 0, 0, 0));
        cyc("beq_not", ex(9, 0, 0, 0));
        funct3 = 3'b001;
        cyc("bne1_fetch", ex(0, 1, 1, 0));
        cyc("bne1_decode", ex(1, 0, 0, 0));
        cyc("bne_taken", ex(9, 0, 1, 0));
        zero = 1;
        cyc("bne2_fetch", ex(0, 1, 1, 0));
        cyc("bne2_decode", ex(1, 0, 0, 0));
        cyc("bne_not", ex(9, 0, 0, 0));
        funct3 = 3'b100;
        cyc("blt_fetch", ex(0, 1, 1, 0));
        cyc("blt_decode", ex(1, 0, 0, 0));
        cyc("blt_not", ex(9, 0, 0, 0));

        // jal, addi, plain add (funct7=0)
        opcode = 7'b1101111; zero = 0;
        cyc("jal_fetch", ex(0, 1, 1, 0));
        cyc("jal_decode", ex(1, 0, 0, 0));
        cyc("jal_exec", ex(10, 0, 0, 0));
        opcode = 7'b0010011; funct7 = 7'b0100000;
        cyc("addi_fetch", ex(0, 1, 1, 0));
        cyc("addi_decode", ex(1, 0, 0, 0));
        cyc("addi_exec", ex(7, 0, 0, 0));
        cyc("addi_wb", ex(8, 0, 0, 0));
        opcode = 7'b0110011; funct7 = 7'b0000000;
        cyc("add0_fetch", ex(0, 1, 1, 0));
        cyc("add0_decode", ex(1, 0, 0, 0));
        cyc("add0_exec", ex(6, 0, 0, 0));
        cyc("add0_wb", ex(8, 0, 0, 0));

        // undecoded opcode
        opcode = 7'b1111111;
        cyc("ill_fetch", ex(0, 1, 1, 0));
        cyc("ill_decode", ex(1, 0, 0, 0));
`ifdef MCTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) cyc($sformatf("trap%0d", i), ex(11, 0, 0, 0));
        reset = 1;
        cyc("trap_reset", '0);
        reset = 0;
`endif

        // reset while a store is stalled in MEM_WRITE
        opcode = 7'b0100011;
        cyc("sw2_fetch", ex(0, 1, 1, 0));
        cyc("sw2_decode", ex(1, 0, 0, 0));
        cyc("sw2_addr", ex(2, 0, 0, 0));
        mem_ready = 0;
        cyc("sw2_stall", ex(5, 0, 0, 0));
        reset = 1;
        cyc("sw2_reset", '0);
        reset = 0; mem_ready = 1;
        cyc("post_reset_fetch", ex(0, 1, 1, 0));

        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
